// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key code type, sweep result type and key map for the keypad path
// Exports: key_code_t (shared with the display path), res_kind_t, sweep_res_t,
//          KEY_MAP (indexed {row, col}) and RES_IDLE (the "no key" result).
package keypad_pkg;
   typedef logic [3:0] key_code_t;
   typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_kind_t;
   typedef struct packed {
      res_kind_t kind;
      key_code_t code;
   } sweep_res_t;
   localparam key_code_t KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'h0, 4'hF, 4'hE, 4'hD
   };
   // Non-single results always carry code 0 so whole-struct equality is meaningful.
   localparam sweep_res_t RES_IDLE = '{kind: RES_NONE, code: 4'h0};
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs
// Ports: clk, rst (sync, active-high), d (async input, W bits), q (synchronized output).
module sync_2ff #(
   parameter int W = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;
   always_ff @(posedge clk)
      if (rst) {q, meta} <= {RST_VAL, RST_VAL};
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scanner with per-sweep resolution and debounce
// Ports: clk, rst (sync, active-high); row_n (active-low rows), col_n (one column driven low);
//        key_code (last debounced single key), key_pressed (single key held),
//        key_valid (one-cycle strobe on a newly pressed key), multi_key (several keys held).
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int COL_CYCLES      = 125_000,
   parameter int DEBOUNCE_SWEEPS = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output key_code_t key_code,
   output logic      key_pressed,
   output logic      key_valid,
   output logic      multi_key
);
   localparam int CW = $clog2(COL_CYCLES);
   localparam int DW = $clog2(DEBOUNCE_SWEEPS + 1);
   localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_SWEEPS);
   logic [3:0]    row_s;
   logic [CW-1:0] cyc;
   logic [1:0]    col_idx;
   logic [15:0]   acc, hits;
   logic [DW-1:0] cnt, cnt_next;
   sweep_res_t    cand, res, prev;
   logic          tc, sweep_done, same, upd;
   sync_2ff #(.W(4), .RST_VAL(4'hF)) u_row_sync (
      .clk(clk),
      .rst(rst),
      .d(row_n),
      .q(row_s)
   );
   assign tc         = cyc == CW'(COL_CYCLES - 1);
   assign sweep_done = tc && col_idx == 2'd3;
   assign col_n      = ~(4'b0001 << col_idx);
   // Each column overwrites its own four bits of the {row, col} map, so the
   // accumulator never needs an explicit clear between sweeps.
   always_comb begin
      hits = acc;
      for (int r = 0; r < 4; r++) hits[{r[1:0], col_idx}] = ~row_s[r];
      res = RES_IDLE;
      for (int i = 0; i < 16; i++) if (hits[i]) res = '{kind: RES_SINGLE, code: KEY_MAP[i]};
      if ($countones(hits) > 1) res = '{kind: RES_MULTI, code: 4'h0};
   end
   assign same     = res == cand;
   assign cnt_next = same ? (cnt == D_MAX ? cnt : cnt + 1'b1) : DW'(1);
   // Stable state moves only on the sweep where the count first reaches the threshold.
   assign upd      = sweep_done && cnt_next == D_MAX && !(same && cnt == D_MAX);
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc         <= '0;
         col_idx     <= '0;
         acc         <= '0;
         cand        <= RES_IDLE;
         cnt         <= '0;
         prev        <= RES_IDLE;
         key_code    <= 4'h0;
         key_pressed <= 1'b0;
         key_valid   <= 1'b0;
         multi_key   <= 1'b0;
      end else begin
         cyc       <= tc ? '0 : cyc + 1'b1;
         key_valid <= 1'b0;
         if (tc) begin
            col_idx <= col_idx + 1'b1;
            acc     <= hits;
         end
         if (sweep_done) begin
            cand <= res;
            cnt  <= cnt_next;
         end
         if (upd) begin
            prev        <= res;
            key_pressed <= res.kind == RES_SINGLE;
            multi_key   <= res.kind == RES_MULTI;
            if (res.kind == RES_SINGLE) key_code <= res.code;
            key_valid   <= res.kind == RES_SINGLE && res != prev;
         end
      end
   end
endmodule
